// File: rtl/utlb_addr_trans_pkg.sv
// Shared types for utlb_addr_trans: CSR and main-TLB structs, uTLB entry, response and FSM state.
// entry_resp() turns a (cached or freshly searched) TLB entry into a translated response.
package utlb_addr_trans_pkg;

    localparam logic [5:0] PS_4K   = 6'd12;
    localparam logic [5:0] PS_HUGE = 6'd21;

    typedef struct packed {
        logic       plv0;
        logic       plv3;
        logic [1:0] mat;
        logic [2:0] pseg;
        logic [2:0] vseg;
    } dmw_t;

    typedef struct packed {
        logic        found;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  mat;
        logic        v;
        logic        d;
        logic [1:0]  plv;
    } tlb_result_t;

    typedef struct packed {
        logic        valid;
        logic [18:0] vppn;
        logic        va12;
        logic [9:0]  asid;
        logic        g;
        logic        huge;
        logic [19:0] ppn;
        logic [1:0]  mat;
        logic        v;
        logic        d;
        logic [1:0]  plv;
    } utlb_entry_t;

    typedef struct packed {
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        page_fault;
        logic        page_invalid;
        logic        page_modify;
        logic        plv_fault;
    } resp_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } utlb_state_t;

    function automatic resp_t entry_resp(
        input utlb_entry_t e,
        input logic        found,
        input logic [20:0] va_lo,
        input logic        is_store,
        input logic [1:0]  plv
    );
        resp_t r;
        r = '0;
        r.page_fault = !found;
        if (found) begin
            r.pa           = e.huge ? {e.ppn[19:9], va_lo} : {e.ppn, va_lo[11:0]};
            r.mat          = e.mat;
            r.page_invalid = !e.v;
            r.plv_fault    = e.v && (plv > e.plv);
            r.page_modify  = e.v && !r.plv_fault && is_store && !e.d;
        end
        return r;
    endfunction

endpackage

// File: rtl/utlb_lookup.sv
// Fully-associative uTLB tag match; lowest matching index wins.
module utlb_lookup
    import utlb_addr_trans_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  utlb_entry_t      entries [ENTRIES],
    input  logic [19:0]      vpn,
    input  logic [9:0]       asid,
    output logic             hit,
    output logic [IDX_W-1:0] index,
    output utlb_entry_t      entry
);

    logic [ENTRIES-1:0] match;

    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = entries[i].valid
                    && (entries[i].g || (entries[i].asid == asid))
                    && (entries[i].huge ? (entries[i].vppn[18:8] == vpn[19:9])
                                        : ({entries[i].vppn, entries[i].va12} == vpn));
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        entry = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit   = 1'b1;
                index = IDX_W'(i);
                entry = entries[i];
            end
        end
    end

endmodule

// File: rtl/utlb_addr_trans.sv
// Pipelined VA->PA translator: direct access, DMW windows, micro-TLB, main-TLB search on miss.
// Define UTLB_HUGE_PAGE_EN to cache ps==21 search results as 2 MB huge entries.
module utlb_addr_trans
    import utlb_addr_trans_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int DMW_NUM = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_va,
    input  logic        req_is_store,
    input  logic        direct_access,
    input  logic [1:0]  direct_access_mat,
    input  logic [1:0]  plv,
    input  logic [9:0]  asid,
    input  dmw_t        dmw [DMW_NUM],
    input  logic        inv_all,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_pa,
    output logic [1:0]  resp_mat,
    output logic        resp_page_fault,
    output logic        resp_page_invalid,
    output logic        resp_page_modify,
    output logic        resp_plv_fault,
    output logic        tlb_s_req,
    input  logic        tlb_s_grant,
    output logic [18:0] tlb_s_vppn,
    output logic        tlb_s_va_bit12,
    output logic [9:0]  tlb_s_asid,
    input  tlb_result_t tlb_s_result
);

    // state  | meaning
    // S_IDLE | ready; DA/DMW/uTLB resolved on the accept cycle
    // S_REQ  | tlb_s_req held until tlb_s_grant
    // S_WAIT | main-TLB result valid; refill and build response
    // S_RESP | response held until resp_ready

    localparam int IDX_W = $clog2(ENTRIES);

    utlb_state_t      state;
    utlb_entry_t      entries [ENTRIES];
    logic [IDX_W-1:0] rr_ptr;
    logic [31:0]      rq_va;
    logic             rq_is_store;
    logic [1:0]       rq_plv;
    logic [9:0]       rq_asid;
    logic             inv_pend;
    resp_t            resp_q;

    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx_unused;
    utlb_entry_t      lk_entry;
    logic             dmw_hit;
    dmw_t             dmw_sel;
    logic             fast_hit;
    resp_t            fast_resp;
    utlb_entry_t      new_entry;
    logic             refill_huge;
    logic             has_free;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim;

    utlb_lookup #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_lookup (
        .entries (entries),
        .vpn     (req_va[31:12]),
        .asid    (asid),
        .hit     (lk_hit),
        .index   (lk_idx_unused),
        .entry   (lk_entry)
    );

`ifdef UTLB_HUGE_PAGE_EN
    assign refill_huge = (tlb_s_result.ps == PS_HUGE);
`else
    logic unused_ps;
    assign refill_huge = 1'b0;
    assign unused_ps   = (tlb_s_result.ps != PS_4K);
`endif

    assign req_ready      = (state == S_IDLE);
    assign tlb_s_vppn     = rq_va[31:13];
    assign tlb_s_va_bit12 = rq_va[12];
    assign tlb_s_asid     = rq_asid;

    assign resp_pa           = resp_q.pa;
    assign resp_mat          = resp_q.mat;
    assign resp_page_fault   = resp_q.page_fault;
    assign resp_page_invalid = resp_q.page_invalid;
    assign resp_page_modify  = resp_q.page_modify;
    assign resp_plv_fault    = resp_q.plv_fault;

    // Resolution on the live request so hits/DMW/DA respond one cycle after acceptance.
    always_comb begin
        dmw_hit = 1'b0;
        dmw_sel = '0;
        for (int i = DMW_NUM - 1; i >= 0; i--) begin
            if ((req_va[31:29] == dmw[i].vseg)
                && (((plv == 2'd0) && dmw[i].plv0) || ((plv == 2'd3) && dmw[i].plv3))) begin
                dmw_hit = 1'b1;
                dmw_sel = dmw[i];
            end
        end

        fast_resp = '0;
        fast_hit  = 1'b1;
        if (direct_access) begin
            fast_resp.pa  = req_va;
            fast_resp.mat = direct_access_mat;
        end else if (dmw_hit) begin
            fast_resp.pa  = {dmw_sel.pseg, req_va[28:0]};
            fast_resp.mat = dmw_sel.mat;
        end else if (lk_hit) begin
            fast_resp = entry_resp(lk_entry, 1'b1, req_va[20:0], req_is_store, plv);
        end else begin
            fast_hit = 1'b0;
        end
    end

    // The search is keyed by the requesting ASID, so refills are cached as non-global.
    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.vppn  = rq_va[31:13];
        new_entry.va12  = rq_va[12];
        new_entry.asid  = rq_asid;
        new_entry.g     = 1'b0;
        new_entry.huge  = refill_huge;
        new_entry.ppn   = tlb_s_result.ppn;
        new_entry.mat   = tlb_s_result.mat;
        new_entry.v     = tlb_s_result.v;
        new_entry.d     = tlb_s_result.d;
        new_entry.plv   = tlb_s_result.plv;
    end

    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!entries[i].valid) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        victim = has_free ? free_idx : rr_ptr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            rq_va       <= '0;
            rq_is_store <= 1'b0;
            rq_plv      <= '0;
            rq_asid     <= '0;
            inv_pend    <= 1'b0;
            resp_q      <= '0;
            resp_valid  <= 1'b0;
            tlb_s_req   <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        rq_va       <= req_va;
                        rq_is_store <= req_is_store;
                        rq_plv      <= plv;
                        rq_asid     <= asid;
                        if (fast_hit) begin
                            resp_q     <= fast_resp;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            tlb_s_req <= 1'b1;
                            inv_pend  <= 1'b0;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (inv_all) begin
                        inv_pend <= 1'b1;
                    end
                    if (tlb_s_grant) begin
                        tlb_s_req <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    resp_q     <= entry_resp(new_entry, tlb_s_result.found, rq_va[20:0],
                                             rq_is_store, rq_plv);
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                    if (tlb_s_result.found && !inv_pend && !inv_all) begin
                        entries[victim] <= new_entry;
                        if (!has_free) begin
                            rr_ptr <= rr_ptr + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Placed last so a flush overrides a same-cycle refill.
            if (inv_all) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    entries[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule
